mc_control: RTL and testbench

Multi-cycle successor to the single-cycle control decoder for the RV32I core.
- An FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over one shared, variable-latency memory port with a ready handshake.
- It generates all datapath strobes, including PC select and write.
- It traps on illegal opcodes and on memory timeouts.
- It sits between the instruction register, the ALU/branch compare unit and the memory interface.

---
 rtl/ctl_pkg.sv | 49 ++++
 rtl/mc_control_wait_timer.sv | 41 ++++
 rtl/mc_control.sv | 199 +++++++++++++++++++
 tb/tb_mc_control.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit:
// FSM states, ALU operation class, write-back / PC source selects and
// the base opcodes the control unit recognises.
package ctl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } mc_state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'd0,
    ALUOP_FUNCT  = 2'd1,
    ALUOP_BRANCH = 2'd2
  } aluop_t;

  localparam logic [2:0] CTL_MEMTOREG_ALU = 3'd0;
  localparam logic [2:0] CTL_MEMTOREG_MEM = 3'd1;
  localparam logic [2:0] CTL_MEMTOREG_PC4 = 3'd2;
  localparam logic [2:0] CTL_MEMTOREG_IMM = 3'd3;

  localparam logic [1:0] CTL_PCSEL_PCPLUS4   = 2'd0;
  localparam logic [1:0] CTL_PCSEL_PCPLUSIMM = 2'd1;
  localparam logic [1:0] CTL_PCSEL_RPLUSIMM  = 2'd2;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // True for every opcode the multi-cycle sequencer knows how to execute.
  function automatic logic opc_legal(input logic [6:0] opc);
    case (opc)
      OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: opc_legal = 1'b1;
      default:                               opc_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_wait_timer.sv
// mc_wait_timer: counts consecutive cycles a memory request has been left
// waiting for mem_ready and flags the cycle on which it runs out of patience.
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: a state change restarts the count, a waiting cycle advances it.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wait_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Only a cycle that is still waiting can expire; a handshake on the last
  // allowed cycle therefore wins.
  assign expired_o = wait_i && (cnt_q == LAST);

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle control FSM for the RV32I core. Sequences each
// instruction through FETCH/DECODE/EXEC/MEM/WB over a single handshaked
// memory port and traps on illegal opcodes or memory timeouts.
// Optional MC_CONTROL_PERF_EN adds retired-instruction and stall counters.
module mc_control
  import ctl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       inst_opc,
  input  logic             take_branch,
  input  logic             mem_ready,
  output logic [1:0]       CTL_PcSel,
  output logic             CTL_PcWrite,
  output logic             CTL_IrWrite,
  output logic             CTL_IorD,
  output logic             CTL_MemRead,
  output logic             CTL_MemWrite,
  output logic             CTL_RegWrite,
  output aluop_t           CTL_AluOp,
  output logic             CTL_AluSrc,
  output logic [2:0]       CTL_MemToReg,
  output mc_state_t        state_o,
  output logic             illegal_o,
  output logic             timeout_o
`ifdef MC_CONTROL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_retired,
  output logic [CNT_W-1:0] perf_stall
`endif
);

  if (MEM_TIMEOUT < 1 || CNT_W < 1) begin : g_bad_param
    $error("mc_control: MEM_TIMEOUT and CNT_W must be at least 1");
  end

  mc_state_t state_q, state_d;
  logic      illegal_q, timeout_q;
  logic      set_ill, set_to;
  logic      mem_wait, expired;

  // A memory request is outstanding in FETCH and MEM until mem_ready.
  assign mem_wait = ((state_q == FETCH) || (state_q == MEM)) && !mem_ready;

  mc_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .wait_i    (mem_wait),
    .clr_i     (state_d != state_q),
    .expired_o (expired)
  );

  // Next-state and strobe decode; rst silences every strobe so a request in flight is dropped.
  always_comb begin
    state_d      = state_q;
    set_ill      = 1'b0;
    set_to       = 1'b0;
    CTL_PcSel    = CTL_PCSEL_PCPLUS4;
    CTL_PcWrite  = 1'b0;
    CTL_IrWrite  = 1'b0;
    CTL_IorD     = 1'b0;
    CTL_MemRead  = 1'b0;
    CTL_MemWrite = 1'b0;
    CTL_RegWrite = 1'b0;
    CTL_AluOp    = ALUOP_ADD;
    CTL_AluSrc   = 1'b0;
    CTL_MemToReg = CTL_MEMTOREG_ALU;
    case (state_q)
      FETCH: begin
        CTL_MemRead = 1'b1;
        if (mem_ready) begin
          CTL_IrWrite = 1'b1;
          CTL_PcWrite = 1'b1;
          state_d     = DECODE;
        end else if (expired) begin
          set_to  = 1'b1;
          state_d = TRAP;
        end
      end
      DECODE: begin
        if (opc_legal(inst_opc)) begin
          state_d = EXEC;
        end else begin
          set_ill = 1'b1;
          state_d = TRAP;
        end
      end
      EXEC: begin
        state_d = WB;
        case (inst_opc)
          OPC_R: CTL_AluOp = ALUOP_FUNCT;
          OPC_I: begin
            CTL_AluOp  = ALUOP_FUNCT;
            CTL_AluSrc = 1'b1;
          end
          OPC_LOAD, OPC_STORE: begin
            CTL_AluSrc = 1'b1;
            state_d    = MEM;
          end
          OPC_BRANCH: begin
            CTL_AluOp   = ALUOP_BRANCH;
            CTL_PcSel   = CTL_PCSEL_PCPLUSIMM;
            CTL_PcWrite = take_branch;
            state_d     = FETCH;
          end
          OPC_JAL: begin
            CTL_PcSel   = CTL_PCSEL_PCPLUSIMM;
            CTL_PcWrite = 1'b1;
          end
          OPC_JALR: begin
            CTL_PcSel   = CTL_PCSEL_RPLUSIMM;
            CTL_PcWrite = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        CTL_IorD     = 1'b1;
        CTL_MemRead  = (inst_opc == OPC_LOAD);
        CTL_MemWrite = (inst_opc == OPC_STORE);
        if (mem_ready) begin
          state_d = (inst_opc == OPC_LOAD) ? WB : FETCH;
        end else if (expired) begin
          set_to  = 1'b1;
          state_d = TRAP;
        end
      end
      WB: begin
        CTL_RegWrite = 1'b1;
        state_d      = FETCH;
        case (inst_opc)
          OPC_LOAD:           CTL_MemToReg = CTL_MEMTOREG_MEM;
          OPC_JAL, OPC_JALR:  CTL_MemToReg = CTL_MEMTOREG_PC4;
          OPC_LUI:            CTL_MemToReg = CTL_MEMTOREG_IMM;
          default:            CTL_MemToReg = CTL_MEMTOREG_ALU;
        endcase
      end
      TRAP: state_d = TRAP;
      default: state_d = FETCH;
    endcase
    if (rst) begin
      CTL_PcSel    = CTL_PCSEL_PCPLUS4;
      CTL_PcWrite  = 1'b0;
      CTL_IrWrite  = 1'b0;
      CTL_IorD     = 1'b0;
      CTL_MemRead  = 1'b0;
      CTL_MemWrite = 1'b0;
      CTL_RegWrite = 1'b0;
      CTL_AluOp    = ALUOP_ADD;
      CTL_AluSrc   = 1'b0;
      CTL_MemToReg = CTL_MEMTOREG_ALU;
    end
  end

  // State register and sticky trap flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_ill) illegal_q <= 1'b1;
      if (set_to)  timeout_q <= 1'b1;
    end
  end

  assign state_o   = state_q;
  assign illegal_o = illegal_q;
  assign timeout_o = timeout_q;

`ifdef MC_CONTROL_PERF_EN
  logic [CNT_W-1:0] retired_q, stall_q;
  logic             retire;

  assign retire = (state_d == FETCH) &&
                  ((state_q == EXEC) || (state_q == MEM) || (state_q == WB));

  // Free-running, wrapping performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (retire)   retired_q <= retired_q + 1'b1;
      if (mem_wait) stall_q   <= stall_q + 1'b1;
    end
  end

  assign perf_retired = retired_q;
  assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: the stimulus process drives one cycle at a
// time and queues the hand-computed strobes/state for that cycle; a monitor
// pops and compares on the falling edge.
module tb_mc_control;
  import ctl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] inst_opc;
  logic       take_branch;
  logic       mem_ready;
  logic [1:0] CTL_PcSel;
  logic       CTL_PcWrite, CTL_IrWrite, CTL_IorD, CTL_MemRead, CTL_MemWrite;
  logic       CTL_RegWrite, CTL_AluSrc;
  aluop_t     CTL_AluOp;
  logic [2:0] CTL_MemToReg;
  mc_state_t  state_o;
  logic       illegal_o, timeout_o;
`ifdef MC_CONTROL_PERF_EN
  logic [31:0] perf_retired, perf_stall;
`endif

  always #5 clk = ~clk;

  mc_control #(
    .MEM_TIMEOUT (4),
    .CNT_W       (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_opc     (inst_opc),
    .take_branch  (take_branch),
    .mem_ready    (mem_ready),
    .CTL_PcSel    (CTL_PcSel),
    .CTL_PcWrite  (CTL_PcWrite),
    .CTL_IrWrite  (CTL_IrWrite),
    .CTL_IorD     (CTL_IorD),
    .CTL_MemRead  (CTL_MemRead),
    .CTL_MemWrite (CTL_MemWrite),
    .CTL_RegWrite (CTL_RegWrite),
    .CTL_AluOp    (CTL_AluOp),
    .CTL_AluSrc   (CTL_AluSrc),
    .CTL_MemToReg (CTL_MemToReg),
    .state_o      (state_o),
    .illegal_o    (illegal_o),
    .timeout_o    (timeout_o)
`ifdef MC_CONTROL_PERF_EN
    ,
    .perf_retired (perf_retired),
    .perf_stall   (perf_stall)
`endif
  );

  // Strobe vector: {PcSel[2], PcWrite, IrWrite, IorD, MemRead, MemWrite,
  //                 RegWrite, AluOp[2], AluSrc, MemToReg[3]}
  function automatic logic [13:0] sb(input logic [1:0] ps, input logic pw, input logic iw,
                                     input logic iod, input logic mr, input logic mw,
                                     input logic rw, input logic [1:0] ao, input logic as,
                                     input logic [2:0] m2r);
    return {ps, pw, iw, iod, mr, mw, rw, ao, as, m2r};
  endfunction

  localparam logic [13:0] N      = 14'd0;
  localparam logic [13:0] FH     = sb(2'd0, 1, 1, 0, 1, 0, 0, 2'd0, 0, 3'd0);
  localparam logic [13:0] FW     = sb(2'd0, 0, 0, 0, 1, 0, 0, 2'd0, 0, 3'd0);
  localparam logic [13:0] EX_R   = sb(2'd0, 0, 0, 0, 0, 0, 0, 2'd1, 0, 3'd0);
  localparam logic [13:0] EX_LS  = sb(2'd0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 3'd0);
  localparam logic [13:0] MEM_LD = sb(2'd0, 0, 0, 1, 1, 0, 0, 2'd0, 0, 3'd0);
  localparam logic [13:0] MEM_ST = sb(2'd0, 0, 0, 1, 0, 1, 0, 2'd0, 0, 3'd0);
  localparam logic [13:0] WB0    = sb(2'd0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 3'd0);
  localparam logic [13:0] WB1    = sb(2'd0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 3'd1);
  localparam logic [13:0] WB2    = sb(2'd0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 3'd2);
  localparam logic [13:0] BR_T   = sb(2'd1, 1, 0, 0, 0, 0, 0, 2'd2, 0, 3'd0);
  localparam logic [13:0] BR_N   = sb(2'd1, 0, 0, 0, 0, 0, 0, 2'd2, 0, 3'd0);
  localparam logic [13:0] JR     = sb(2'd2, 1, 0, 0, 0, 0, 0, 2'd0, 0, 3'd0);

  localparam logic [6:0] O_R  = 7'b0110011;
  localparam logic [6:0] O_LD = 7'b0000011;
  localparam logic [6:0] O_ST = 7'b0100011;
  localparam logic [6:0] O_BR = 7'b1100011;
  localparam logic [6:0] O_JR = 7'b1100111;
  localparam logic [6:0] O_IL = 7'b1111111;

  typedef struct {
    string       name;
    logic        chk_st;
    mc_state_t   st;
    logic [13:0] sb;
    logic        ill;
    logic        to;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  wire [13:0] act = {CTL_PcSel, CTL_PcWrite, CTL_IrWrite, CTL_IorD, CTL_MemRead,
                     CTL_MemWrite, CTL_RegWrite, CTL_AluOp, CTL_AluSrc, CTL_MemToReg};

  // Drive one cycle of inputs and queue what the DUT must show in that cycle.
  task automatic step(input string nm, input logic r, input logic [6:0] opc,
                      input logic tbr, input logic rdy, input logic chk,
                      input mc_state_t st, input logic [13:0] s,
                      input logic ill, input logic to);
    exp_t e;
    rst = r; inst_opc = opc; take_branch = tbr; mem_ready = rdy;
    e.name = nm; e.chk_st = chk; e.st = st; e.sb = s; e.ill = ill; e.to = to;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the oldest expectation against the DUT mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (act !== e.sb) begin
          errors++;
          $display("FAIL %s strobes: got %b expected %b", e.name, act, e.sb);
        end
        if (e.chk_st) begin
          checks++;
          if (state_o !== e.st || illegal_o !== e.ill || timeout_o !== e.to) begin
            errors++;
            $display("FAIL %s state/flags: got %0d ill=%b to=%b expected %0d ill=%b to=%b",
                     e.name, state_o, illegal_o, timeout_o, e.st, e.ill, e.to);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; inst_opc = O_R; take_branch = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    // reset
    step("rst0", 1, O_R, 0, 1, 0, FETCH, N, 0, 0);
    step("rst1", 1, O_R, 0, 1, 1, FETCH, N, 0, 0);
    // R-type, zero-wait
    step("r_fetch", 0, O_R, 0, 1, 1, FETCH,  FH,   0, 0);
    step("r_dec",   0, O_R, 0, 1, 1, DECODE, N,    0, 0);
    step("r_exec",  0, O_R, 0, 1, 1, EXEC,   EX_R, 0, 0);
    step("r_wb",    0, O_R, 0, 1, 1, WB,     WB0,  0, 0);
    // LOAD with three wait cycles in MEM; ready on the last allowed cycle
    step("ld_fetch", 0, O_LD, 0, 1, 1, FETCH,  FH,     0, 0);
    step("ld_dec",   0, O_LD, 0, 1, 1, DECODE, N,      0, 0);
    step("ld_exec",  0, O_LD, 0, 1, 1, EXEC,   EX_LS,  0, 0);
    step("ld_mem_w0",0, O_LD, 0, 0, 1, MEM,    MEM_LD, 0, 0);
    step("ld_mem_w1",0, O_LD, 0, 0, 1, MEM,    MEM_LD, 0, 0);
    step("ld_mem_w2",0, O_LD, 0, 0, 1, MEM,    MEM_LD, 0, 0);
    step("ld_mem_ok",0, O_LD, 0, 1, 1, MEM,    MEM_LD, 0, 0);
    step("ld_wb",    0, O_LD, 0, 1, 1, WB,     WB1,    0, 0);
`ifdef MC_CONTROL_PERF_EN
    checks++;
    if (perf_stall !== 32'd3 || perf_retired !== 32'd2) begin
      errors++;
      $display("FAIL perf_counters: got stall=%0d retired=%0d expected stall=3 retired=2",
               perf_stall, perf_retired);
    end
`endif
    // BRANCH taken, then not taken (take_branch high outside EXEC is ignored)
    step("bt_fetch", 0, O_BR, 1, 1, 1, FETCH,  FH,   0, 0);
    step("bt_dec",   0, O_BR, 1, 1, 1, DECODE, N,    0, 0);
    step("bt_exec",  0, O_BR, 1, 1, 1, EXEC,   BR_T, 0, 0);
    step("bn_fetch", 0, O_BR, 0, 1, 1, FETCH,  FH,   0, 0);
    step("bn_dec",   0, O_BR, 1, 1, 1, DECODE, N,    0, 0);
    step("bn_exec",  0, O_BR, 0, 1, 1, EXEC,   BR_N, 0, 0);
    // JALR
    step("jr_fetch", 0, O_JR, 0, 1, 1, FETCH,  FH,  0, 0);
    step("jr_dec",   0, O_JR, 0, 1, 1, DECODE, N,   0, 0);
    step("jr_exec",  0, O_JR, 0, 1, 1, EXEC,   JR,  0, 0);
    step("jr_wb",    0, O_JR, 0, 1, 1, WB,     WB2, 0, 0);
    // STORE
    step("st_fetch", 0, O_ST, 0, 1, 1, FETCH,  FH,     0, 0);
    step("st_dec",   0, O_ST, 0, 1, 1, DECODE, N,      0, 0);
    step("st_exec",  0, O_ST, 0, 1, 1, EXEC,   EX_LS,  0, 0);
    step("st_mem",   0, O_ST, 0, 1, 1, MEM,    MEM_ST, 0, 0);
    // fetch timeout after four waiting cycles
    step("to_w0",   0, O_R, 0, 0, 1, FETCH, FW, 0, 0);
    step("to_w1",   0, O_R, 0, 0, 1, FETCH, FW, 0, 0);
    step("to_w2",   0, O_R, 0, 0, 1, FETCH, FW, 0, 0);
    step("to_w3",   0, O_R, 0, 0, 1, FETCH, FW, 0, 0);
    step("to_trap", 0, O_R, 0, 1, 1, TRAP,  N,  0, 1);
    step("to_rst",  1, O_R, 0, 1, 0, FETCH, N,  0, 0);
    // ready arrives on the fourth cycle: handshake wins
    step("nt_w0",   0, O_R, 0, 0, 1, FETCH,  FW,   0, 0);
    step("nt_w1",   0, O_R, 0, 0, 1, FETCH,  FW,   0, 0);
    step("nt_w2",   0, O_R, 0, 0, 1, FETCH,  FW,   0, 0);
    step("nt_ok",   0, O_R, 0, 1, 1, FETCH,  FH,   0, 0);
    step("nt_dec",  0, O_R, 0, 1, 1, DECODE, N,    0, 0);
    step("nt_exec", 0, O_R, 0, 1, 1, EXEC,   EX_R, 0, 0);
    step("nt_wb",   0, O_R, 0, 1, 1, WB,     WB0,  0, 0);
    // illegal opcode traps and stays trapped
    step("il_fetch", 0, O_IL, 0, 1, 1, FETCH,  FH, 0, 0);
    step("il_dec",   0, O_IL, 0, 1, 1, DECODE, N,  0, 0);
    for (int i = 0; i < 10; i++) begin
      step("il_trap", 0, O_IL, 1, 1, 1, TRAP, N, 1, 0);
    end
    step("il_rst",   1, O_IL, 0, 1, 0, FETCH, N,  0, 0);
    step("il_after", 0, O_R,  0, 1, 1, FETCH, FH, 0, 0);
    // reset in the middle of a waiting load drops the request
    step("mr_dec",  0, O_LD, 0, 1, 1, DECODE, N,      0, 0);
    step("mr_exec", 0, O_LD, 0, 1, 1, EXEC,   EX_LS,  0, 0);
    step("mr_mem",  0, O_LD, 0, 0, 1, MEM,    MEM_LD, 0, 0);
    step("mr_rst",  1, O_LD, 0, 0, 0, FETCH,  N,      0, 0);
    step("mr_fetch",0, O_LD, 0, 1, 1, FETCH,  FH,     0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
